// File: rtl/wide_alu_ctrl.sv
// Register-mapped sequencer for a 256-bit ALU behind a 32-bit register bus.
// Owns operand/result storage, the issue/wait handshake and a result watchdog.
module wide_alu_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int OP_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [255:0]          alu_a_o,
  output logic [255:0]          alu_b_o,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic                  alu_valid_o,
  input  logic                  alu_ready_i,
  input  logic                  alu_res_valid_i,
  input  logic [255:0]          alu_res_i,
  output logic                  irq_o
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0][31:0]    a_q, b_q, res_q;
  logic [OP_WIDTH-1:0] op_q;
  logic                done_q, done_d;
  logic                tout_q, tout_d;
  logic                irq_en_q, irq_en_d;
  logic                irq_q;
  logic                rvalid_q, err_q;
  logic [31:0]         rdata_q, rdata_s;

  logic [WIDX_W-1:0]   widx_s;
  logic [2:0]          res_idx_s;
  logic                is_a_s, is_b_s, is_ctrl_s, is_stat_s, is_res_s, is_irqen_s, mapped_s;
  logic                wr_s, rd_s, busy_s, blocked_s, start_s;
  logic                capture_s, timeout_s;
  logic                unused_s;

  assign widx_s     = addr_i[ADDR_WIDTH-1:2];
  assign unused_s   = ^addr_i[1:0];
  assign is_a_s     = (widx_s < WIDX_W'(8));
  assign is_b_s     = (widx_s >= WIDX_W'(8)) && (widx_s < WIDX_W'(16));
  assign is_ctrl_s  = (widx_s == WIDX_W'(16));
  assign is_stat_s  = (widx_s == WIDX_W'(17));
  assign is_res_s   = (widx_s >= WIDX_W'(18)) && (widx_s <= WIDX_W'(25));
  assign is_irqen_s = (widx_s == WIDX_W'(26));
  assign mapped_s   = (widx_s <= WIDX_W'(26));
  // RESULT starts at word 18, so its slot is the low three index bits minus 2 (mod 8)
  assign res_idx_s  = widx_s[2:0] - 3'd2;

  assign wr_s      = req_i & we_i;
  assign rd_s      = req_i & ~we_i;
  assign busy_s    = (state_q != S_IDLE);
  assign blocked_s = wr_s & busy_s & (is_a_s | is_b_s | is_ctrl_s);
  assign start_s   = wr_s & ~busy_s & is_ctrl_s & wdata_i[0];

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;
  assign alu_op_o = op_q;
  assign irq_o    = irq_q;

  // FSM state and watchdog counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) state_d = S_ISSUE;
        else         state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (alu_ready_i) state_d = S_WAIT;
        else             state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (capture_s | timeout_s) state_d = S_IDLE;
        else                       state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ALU request and the completion strobes seen in WAIT
  always_comb begin
    alu_valid_o = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_q)
      S_ISSUE: alu_valid_o = 1'b1;
      S_WAIT: begin
        capture_s = alu_res_valid_i;
        timeout_s = ~alu_res_valid_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
      end
      default: alu_valid_o = 1'b0;
    endcase
  end

  // Watchdog counts WAIT cycles starting at 1 on the cycle WAIT is entered
  always_comb begin
    if ((state_q == S_ISSUE) && alu_ready_i) begin
      cnt_d = CNT_W'(1);
    end else if ((state_q == S_WAIT) && !(capture_s | timeout_s)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Operand and opcode registers; frozen while an operation is in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (wr_s && !busy_s && is_a_s) a_q[widx_s[2:0]] <= wdata_i;
      if (wr_s && !busy_s && is_b_s) b_q[widx_s[2:0]] <= wdata_i;
      if (wr_s && !busy_s && is_ctrl_s) op_q <= wdata_i[OP_WIDTH:1];
    end
  end

  // Status next-state: W1C and start clear first, so a same-cycle set wins
  always_comb begin
    done_d   = done_q;
    tout_d   = tout_q;
    irq_en_d = irq_en_q;
    if (wr_s && is_stat_s) begin
      done_d = done_q & ~wdata_i[1];
      tout_d = tout_q & ~wdata_i[2];
    end else begin
      done_d = done_q;
      tout_d = tout_q;
    end
    if (start_s) begin
      done_d = 1'b0;
      tout_d = 1'b0;
    end else begin
      done_d = done_d | capture_s;
      tout_d = tout_d | timeout_s;
    end
    if (wr_s && is_irqen_s) irq_en_d = wdata_i[0];
    else                    irq_en_d = irq_en_q;
  end

  // Status, interrupt and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      done_q   <= done_d;
      tout_q   <= tout_d;
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
      if (capture_s) res_q <= alu_res_i;
    end
  end

  // Read-data mux over the register map
  always_comb begin
    rdata_s = 32'd0;
    if (is_a_s) begin
      rdata_s = a_q[widx_s[2:0]];
    end else if (is_b_s) begin
      rdata_s = b_q[widx_s[2:0]];
    end else if (is_ctrl_s) begin
      rdata_s[OP_WIDTH:1] = op_q;
    end else if (is_stat_s) begin
      rdata_s[2:0] = {tout_q, done_q, busy_s};
    end else if (is_res_s) begin
      rdata_s = res_q[res_idx_s];
    end else if (is_irqen_s) begin
      rdata_s[0] = irq_en_q;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Bus response, one cycle after each granted request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & (~mapped_s | blocked_s);
      rdata_q  <= (rd_s && mapped_s) ? rdata_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_wide_alu_ctrl.sv
// Scoreboard bench for wide_alu_ctrl: bus responses are queued from a reference
// model at issue time and compared by an independent monitor when rvalid_o rises.
module tb_wide_alu_ctrl;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst, req, we;
  logic [7:0]   addr;
  logic [31:0]  wdata, rdata;
  logic         gnt, rvalid, err;
  logic [255:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_valid, alu_ready, alu_res_valid, irq;

  wide_alu_ctrl #(.ADDR_WIDTH(8), .OP_WIDTH(3), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_valid_o(alu_valid),
    .alu_ready_i(alu_ready), .alu_res_valid_i(alu_res_valid), .alu_res_i(alu_res),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       n;
  } exp_t;
  exp_t sb[$];

  // reference model state
  logic [31:0] ma[8], mb[8], mres[8];
  logic [2:0]  mop;
  bit          mdone, mto, mien, m_issue, m_wait;
  int          m_wcnt;

  // ALU environment knobs
  bit           hold_ready, stray;
  int           res_at;
  logic [255:0] res_val;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      ma[i] = 32'd0; mb[i] = 32'd0; mres[i] = 32'd0;
    end
    mop = 3'd0; mdone = 1'b0; mto = 1'b0; mien = 1'b0;
    m_issue = 1'b0; m_wait = 1'b0; m_wcnt = 0;
  endfunction

  function automatic void ref_resp(input bit w, input logic [7:0] ad,
                                   output logic [31:0] d, output logic e);
    int wi;
    bit busy;
    wi = int'(ad[7:2]);
    busy = m_issue || m_wait;
    d = 32'd0;
    e = 1'b0;
    if (wi > 26)       e = 1'b1;
    else if (w)        e = busy && (wi <= 16);
    else if (wi < 8)   d = ma[wi];
    else if (wi < 16)  d = mb[wi-8];
    else if (wi == 16) d = {28'd0, mop, 1'b0};
    else if (wi == 17) d = {29'd0, mto, mdone, busy};
    else if (wi < 26)  d = mres[wi-18];
    else               d = {31'd0, mien};
  endfunction

  function automatic void ref_step(input bit rq, w, input logic [7:0] ad, input logic [31:0] wd,
                                   input bit rdy, rv, input logic [255:0] res);
    int wi;
    bit busy, wr, start, nd, nt;
    wi = int'(ad[7:2]);
    busy = m_issue || m_wait;
    wr = rq && w;
    nd = mdone; nt = mto; start = 1'b0;
    if (wr && wi == 17) begin
      if (wd[1]) nd = 1'b0;
      if (wd[2]) nt = 1'b0;
    end
    if (wr && wi == 26) mien = wd[0];
    if (wr && !busy) begin
      if (wi < 8) ma[wi] = wd;
      else if (wi < 16) mb[wi-8] = wd;
      else if (wi == 16) begin
        mop = wd[3:1];
        start = wd[0];
      end
    end
    if (start) begin nd = 1'b0; nt = 1'b0; end
    if (m_issue) begin
      if (rdy) begin m_issue = 1'b0; m_wait = 1'b1; m_wcnt = 1; end
    end else if (m_wait) begin
      if (rv) begin
        for (int i = 0; i < 8; i++) mres[i] = res[32*i +: 32];
        nd = 1'b1;
        m_wait = 1'b0;
      end else if (m_wcnt == T) begin
        nt = 1'b1;
        m_wait = 1'b0;
      end else begin
        m_wcnt++;
      end
    end else if (start) begin
      m_issue = 1'b1;
    end
    mdone = nd;
    mto = nt;
  endfunction

  // One bus cycle: drive, predict, clock, then check the free-running outputs
  task automatic cyc(input bit rq, input bit w, input logic [7:0] ad, input logic [31:0] wd,
                     input string nm);
    exp_t x;
    logic [255:0] pa, pb;
    req = rq; we = w; addr = ad; wdata = wd;
    alu_ready = !hold_ready;
    alu_res_valid = (m_wait && m_wcnt == res_at) || stray;
    alu_res = res_val;
    #1;
    chk("gnt", gnt, rq);
    x.n = nm;
    x.d = 32'd0;
    x.e = 1'b0;
    if (rq) ref_resp(w, ad, x.d, x.e);
    ref_step(rq, w, ad, wd, alu_ready, alu_res_valid, alu_res);
    @(posedge clk);
    #1;
    if (rq) sb.push_back(x);
    req = 1'b0; alu_res_valid = 1'b0; stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pa[32*i +: 32] = ma[i];
      pb[32*i +: 32] = mb[i];
    end
    chk("alu_valid", alu_valid, m_issue);
    chk("irq", irq, mdone && mien);
    chk("alu_a", alu_a, pa);
    chk("alu_b", alu_b, pb);
    chk("alu_op", alu_op, mop);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; alu_res_valid = 1'b0; alu_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
  endtask

  // Monitor: each response must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      if (rvalid !== 1'b1 || rdata !== x.d || err !== x.e) begin
        errors++;
        $display("FAIL %s rvalid=%0b rdata=%08h err=%0b, expected rvalid=1 rdata=%08h err=%0b",
                 x.n, rvalid, rdata, err, x.d, x.e);
      end
    end else if (rvalid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rvalid rdata=%08h err=%0b, expected no response", rdata, err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int vc;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'd0; wdata = 32'd0;
    alu_ready = 1'b0; alu_res_valid = 1'b0; alu_res = 256'd0;
    hold_ready = 1'b0; stray = 1'b0; res_at = 0; res_val = 256'd0;
    model_clear();

    do_reset();
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "rst_status");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h48 + 4*i), 32'd0, "rst_result");

    // basic operation with immediate ready and a 5-cycle result
    res_at = 5; res_val = 256'h3;
    cyc(1'b1, 1'b1, 8'h00, 32'h1, "wr_a0");
    cyc(1'b1, 1'b1, 8'h20, 32'h2, "wr_b0");
    cyc(1'b1, 1'b1, 8'h68, 32'h1, "wr_ien");
    vc = 0;
    cyc(1'b1, 1'b1, 8'h40, 32'h3, "start_basic");
    if (alu_valid) vc++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
      if (alu_valid) vc++;
    end
    chk("valid_one_cycle", vc, 1);
    chk("irq_after_done", irq, 1);
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_done");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h48 + 4*i), 32'd0, "result_basic");

    // ALU stalls: operands held, busy writes rejected
    hold_ready = 1'b1; res_at = 3; res_val = rand256();
    cyc(1'b1, 1'b1, 8'h40, 32'h5, "start_stall");
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
    cyc(1'b1, 1'b1, 8'h0C, 32'hDEADBEEF, "wr_a3_busy");
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_busy");
    hold_ready = 1'b0;
    repeat (8) cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
    cyc(1'b1, 1'b0, 8'h48, 32'd0, "result_stall");

    // watchdog: no result ever arrives; status polled every cycle
    res_at = 0; res_val = rand256();
    cyc(1'b1, 1'b1, 8'h40, 32'h7, "start_timeout");
    repeat (22) cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_timeout");
    stray = 1'b1;
    cyc(1'b1, 1'b0, 8'h48, 32'd0, "result_after_stray");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h48 + 4*i), 32'd0, "result_timeout");
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_after_stray");

    // done set and W1C in the same cycle: set wins
    res_at = 4; res_val = rand256();
    cyc(1'b1, 1'b1, 8'h40, 32'h9, "start_w1c");
    for (int i = 0; i < 10; i++) begin
      if (m_wait && m_wcnt == res_at) cyc(1'b1, 1'b1, 8'h44, 32'h2, "w1c_collide");
      else cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_poll");
    end
    chk("irq_collide", irq, 1);
    cyc(1'b1, 1'b1, 8'h44, 32'h2, "w1c_done");
    chk("irq_cleared", irq, 0);
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_cleared");

    // restart while busy and an unmapped read
    hold_ready = 1'b1; res_at = 2; res_val = rand256();
    cyc(1'b1, 1'b1, 8'h40, 32'h3, "start_again");
    cyc(1'b1, 1'b1, 8'h40, 32'hB, "start_busy");
    cyc(1'b1, 1'b0, 8'h70, 32'd0, "unmapped_read");
    cyc(1'b1, 1'b0, 8'h40, 32'd0, "ctrl_read");
    hold_ready = 1'b0;
    repeat (6) cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_again");

    // reset mid-operation, then a stray result
    res_at = 10; res_val = rand256();
    cyc(1'b1, 1'b1, 8'h40, 32'h3, "start_abort");
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
    do_reset();
    stray = 1'b1;
    cyc(1'b1, 1'b0, 8'h44, 32'd0, "status_abort");
    cyc(1'b1, 1'b0, 8'h48, 32'd0, "result_abort");

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      bit rq, w;
      logic [7:0] ad;
      logic [31:0] wd;
      if (!(m_issue || m_wait)) begin
        res_at = $urandom_range(1, 20);
        res_val = rand256();
      end
      hold_ready = ($urandom_range(0, 2) == 0);
      stray = ($urandom_range(0, 15) == 0);
      rq = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      ad = 8'($urandom_range(0, 31) * 4);
      wd = $urandom;
      if (!(m_issue || m_wait) && $urandom_range(0, 5) == 0) begin
        rq = 1'b1; w = 1'b1; ad = 8'h40; wd[0] = 1'b1;
      end
      cyc(rq, w, ad, wd, "rand");
    end

    repeat (3) cyc(1'b0, 1'b0, 8'h00, 32'd0, "idle");
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
